// File: rtl/oled_spi_receiver.sv
// Display-side SPI receiver for an SSD1306-style OLED link.
// Oversamples the SPI pins on clk and rebuilds bytes from them.
// Interprets the addressing commands it receives.
// Turns data bytes into framebuffer write strobes using horizontal addressing.
module oled_spi_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int COLS        = 128,
    parameter int PAGES       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_clk,
    input  logic       spi_mosi,
    input  logic       spi_dc,
    input  logic       spi_cs_n,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_is_data,
    output logic       fb_we,
    output logic [2:0] fb_page,
    output logic [6:0] fb_col,
    output logic [7:0] fb_data,
    output logic       display_on
);

    localparam int CW = $clog2(COLS);
    localparam int PW = $clog2(PAGES);
    // Synchroniser idle value, packed as {cs_n, dc, mosi, clk}: deselected, clock low.
    localparam logic [3:0] SYNC_IDLE = 4'b1000;

    typedef enum logic [2:0] {IDLE, COL_S, COL_E, PG_S, PG_E} state_t;

    // ---------------- input synchronisers ----------------
    // The four pins share one chain so they stay cycle-aligned with each other.
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        logic [3:0] q_reg;
        logic [3:0] d_in;
        if (gi == 0) begin : g_head
            assign d_in = {spi_cs_n, spi_dc, spi_mosi, spi_clk};
        end else begin : g_tail
            assign d_in = g_sync[gi-1].q_reg;
        end
        // One synchroniser stage; reset to the idle bus state.
        always_ff @(posedge clk) begin
            if (rst) q_reg <= SYNC_IDLE;
            else     q_reg <= d_in;
        end
    end

    logic [3:0] sync_last;
    assign sync_last = g_sync[SYNC_STAGES-1].q_reg;

    // ---------------- edge detection ----------------
    logic clk_prev_reg, rise_reg, mosi_d_reg, dc_d_reg, cs_d_reg;

    // Register the detected rising edge together with the data sampled at that edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_prev_reg <= 1'b0;
            rise_reg     <= 1'b0;
            mosi_d_reg   <= 1'b0;
            dc_d_reg     <= 1'b0;
            cs_d_reg     <= 1'b1;
        end else begin
            clk_prev_reg <= sync_last[0];
            rise_reg     <= sync_last[0] & ~clk_prev_reg;
            mosi_d_reg   <= sync_last[1];
            dc_d_reg     <= sync_last[2];
            cs_d_reg     <= sync_last[3];
        end
    end

    // ---------------- deserialiser ----------------
    logic [6:0] shreg_reg;
    logic [2:0] bit_cnt_reg;
    logic       byte_valid_reg, byte_is_data_reg;
    logic [7:0] byte_data_reg;

    // Shift bits MSB first. The 8th bit completes the byte; a deselect drops any partial byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_reg        <= '0;
            bit_cnt_reg      <= '0;
            byte_valid_reg   <= 1'b0;
            byte_data_reg    <= '0;
            byte_is_data_reg <= 1'b0;
        end else begin
            byte_valid_reg <= 1'b0;
            if (cs_d_reg) begin
                bit_cnt_reg <= '0;
            end else if (rise_reg) begin
                shreg_reg   <= {shreg_reg[5:0], mosi_d_reg};
                bit_cnt_reg <= bit_cnt_reg + 3'd1;   // 7 -> 0 closes the byte
                if (bit_cnt_reg == 3'd7) begin
                    byte_valid_reg   <= 1'b1;
                    byte_data_reg    <= {shreg_reg, mosi_d_reg};
                    byte_is_data_reg <= dc_d_reg;
                end
            end
        end
    end

    // ---------------- command parser ----------------
    state_t         state_reg, state_next;
    logic [CW-1:0]  col_reg, col_start_reg, col_end_reg, col_inc;
    logic [PW-1:0]  page_reg, page_start_reg, page_end_reg, page_inc;
    logic           display_on_reg;

    // Parser state register.
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next parser state. A data byte abandons any pending command argument.
    always_comb begin
        state_next = state_reg;
        if (byte_valid_reg) begin
            if (byte_is_data_reg) begin
                state_next = IDLE;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (byte_data_reg == 8'h21)      state_next = COL_S;
                        else if (byte_data_reg == 8'h22) state_next = PG_S;
                    end
                    COL_S:   state_next = COL_E;
                    COL_E:   state_next = IDLE;
                    PG_S:    state_next = PG_E;
                    PG_E:    state_next = IDLE;
                    default: state_next = IDLE;
                endcase
            end
        end
    end

    // Modulo increments, so start>end windows wrap through zero.
    always_comb begin
        col_inc  = (col_reg == CW'(COLS - 1)) ? '0 : col_reg + CW'(1);
        page_inc = (page_reg == PW'(PAGES - 1)) ? '0 : page_reg + PW'(1);
    end

    // Address pointers, window limits and the display-enable flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_reg        <= '0;
            col_start_reg  <= '0;
            col_end_reg    <= CW'(COLS - 1);
            page_reg       <= '0;
            page_start_reg <= '0;
            page_end_reg   <= PW'(PAGES - 1);
            display_on_reg <= 1'b0;
        end else if (byte_valid_reg) begin
            if (byte_is_data_reg) begin
                if (col_reg == col_end_reg) begin
                    col_reg  <= col_start_reg;
                    page_reg <= (page_reg == page_end_reg) ? page_start_reg : page_inc;
                end else begin
                    col_reg <= col_inc;
                end
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (byte_data_reg == 8'hAE)             display_on_reg <= 1'b0;
                        else if (byte_data_reg == 8'hAF)        display_on_reg <= 1'b1;
                        else if (byte_data_reg[7:3] == 5'b10110) page_reg <= byte_data_reg[PW-1:0];
                        else if (byte_data_reg[7:4] == 4'h0)    col_reg[3:0] <= byte_data_reg[3:0];
                        else if (byte_data_reg[7:3] == 5'b00010) col_reg[CW-1:4] <= byte_data_reg[CW-5:0];
                    end
                    COL_S: begin
                        col_start_reg <= byte_data_reg[CW-1:0];
                        col_reg       <= byte_data_reg[CW-1:0];
                    end
                    COL_E: col_end_reg <= byte_data_reg[CW-1:0];
                    PG_S: begin
                        page_start_reg <= byte_data_reg[PW-1:0];
                        page_reg       <= byte_data_reg[PW-1:0];
                    end
                    PG_E:    page_end_reg <= byte_data_reg[PW-1:0];
                    default: ;
                endcase
            end
        end
    end

    // The write strobe comes out in the same cycle as the byte, at the pre-advance pointer.
    assign byte_valid   = byte_valid_reg;
    assign byte_data    = byte_data_reg;
    assign byte_is_data = byte_is_data_reg;
    assign fb_we        = byte_valid_reg & byte_is_data_reg;
    assign fb_page      = page_reg;
    assign fb_col       = col_reg;
    assign fb_data      = byte_data_reg;
    assign display_on   = display_on_reg;

endmodule

// File: tb/tb_oled_spi_receiver.sv
// Directed bench for oled_spi_receiver: a table of command/data bytes plus hand-written corner cases.
module tb_oled_spi_receiver;

    localparam int HALF = 5;   // spi_clk half period in clk cycles

    logic       clk = 1'b0, rst = 1'b1;
    logic       spi_clk = 1'b0, spi_mosi = 1'b0, spi_dc = 1'b0, spi_cs_n = 1'b1;
    logic       byte_valid, byte_is_data, fb_we, display_on;
    logic [7:0] byte_data, fb_data;
    logic [2:0] fb_page;
    logic [6:0] fb_col;

    oled_spi_receiver #(.SYNC_STAGES(2), .COLS(128), .PAGES(8)) dut (
        .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_dc(spi_dc),
        .spi_cs_n(spi_cs_n), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_is_data(byte_is_data), .fb_we(fb_we), .fb_page(fb_page), .fb_col(fb_col),
        .fb_data(fb_data), .display_on(display_on)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: capture every byte_valid pulse and flag strobes that appear without a data byte.
    int         vcount = 0, bv_cyc = 0, we_bad = 0;
    logic [7:0] cap_data = '0, cap_fbd = '0;
    logic       cap_is_data = 1'b0, cap_we = 1'b0;
    logic [2:0] cap_page = '0;
    logic [6:0] cap_col = '0;
    always @(negedge clk) begin
        if (byte_valid) begin
            vcount      <= vcount + 1;
            bv_cyc      <= cyc;
            cap_data    <= byte_data;
            cap_is_data <= byte_is_data;
            cap_we      <= fb_we;
            cap_page    <= fb_page;
            cap_col     <= fb_col;
            cap_fbd     <= fb_data;
        end
        if (fb_we && !(byte_valid && byte_is_data)) we_bad <= we_bad + 1;
    end

    int checks = 0, failures = 0, edge_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Drive n bits of b, MSB first, in SPI mode 0; remember when the 8th rising edge was driven.
    task automatic send_bits(input logic dc, input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            spi_mosi = b[7-i];
            spi_dc   = dc;
            repeat (HALF) @(negedge clk);
            spi_clk = 1'b1;
            if (i == 7) edge_cyc = cyc;
            repeat (HALF) @(negedge clk);
            spi_clk = 1'b0;
        end
    endtask

    // Send one full byte framed by chip select, then wait (bounded) for the receiver to report it.
    task automatic send_byte(input logic dc, input logic [7:0] b);
        int v0;
        v0 = vcount;
        spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        send_bits(dc, b, 8);
        repeat (HALF) @(negedge clk);
        spi_cs_n = 1'b1;
        for (int k = 0; k < 20 && vcount == v0; k++) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    typedef struct {
        logic       dc;
        logic [7:0] b;
        logic       we;
        logic [2:0] pg;
        logic [6:0] col;
        logic       disp;
    } vec_t;

    function automatic vec_t mk(input logic dc, input logic [7:0] b, input logic [2:0] pg,
                                input logic [6:0] col, input logic disp);
        vec_t v;
        v.dc = dc; v.b = b; v.we = dc; v.pg = pg; v.col = col; v.disp = disp;
        return v;
    endfunction

    vec_t vt [0:25];

    initial begin
        int v0;
        // Display on; 3x2 window at cols 5..7, pages 2..3; then a wrapping window.
        vt[0]  = mk(0, 8'hAF, 0, 0, 1);
        vt[1]  = mk(0, 8'h21, 0, 0, 1);
        vt[2]  = mk(0, 8'h05, 0, 0, 1);
        vt[3]  = mk(0, 8'h07, 0, 0, 1);
        vt[4]  = mk(0, 8'h22, 0, 0, 1);
        vt[5]  = mk(0, 8'h02, 0, 0, 1);
        vt[6]  = mk(0, 8'h03, 0, 0, 1);
        vt[7]  = mk(1, 8'h01, 2, 5, 1);
        vt[8]  = mk(1, 8'h02, 2, 6, 1);
        vt[9]  = mk(1, 8'h03, 2, 7, 1);
        vt[10] = mk(1, 8'h04, 3, 5, 1);
        vt[11] = mk(1, 8'h05, 3, 6, 1);
        vt[12] = mk(1, 8'h06, 3, 7, 1);
        vt[13] = mk(1, 8'h07, 2, 5, 1);
        vt[14] = mk(1, 8'h08, 2, 6, 1);
        vt[15] = mk(0, 8'h21, 0, 0, 1);
        vt[16] = mk(0, 8'h7E, 0, 0, 1);
        vt[17] = mk(0, 8'h01, 0, 0, 1);
        vt[18] = mk(0, 8'h22, 0, 0, 1);
        vt[19] = mk(0, 8'h07, 0, 0, 1);
        vt[20] = mk(0, 8'h00, 0, 0, 1);
        vt[21] = mk(1, 8'h11, 7, 126, 1);
        vt[22] = mk(1, 8'h12, 7, 127, 1);
        vt[23] = mk(1, 8'h13, 7, 0, 1);
        vt[24] = mk(1, 8'h14, 7, 1, 1);
        vt[25] = mk(1, 8'h15, 0, 126, 1);

        do_reset();
        check("reset_outputs", {byte_valid, byte_data, byte_is_data, fb_we, fb_page, fb_col, fb_data, display_on}, 0);

        for (int i = 0; i < 26; i++) begin
            v0 = vcount;
            send_byte(vt[i].dc, vt[i].b);
            $display("vec %0d: dc=%0d byte=%02h -> valid=%0d we=%0d p=%0d c=%0d disp=%0d",
                     i, vt[i].dc, vt[i].b, vcount - v0, cap_we, cap_page, cap_col, display_on);
            check($sformatf("vec%0d_count", i), vcount - v0, 1);
            check($sformatf("vec%0d_data", i), cap_data, vt[i].b);
            check($sformatf("vec%0d_is_data", i), cap_is_data, vt[i].dc);
            check($sformatf("vec%0d_we", i), cap_we, vt[i].we);
            if (vt[i].we) begin
                check($sformatf("vec%0d_page", i), cap_page, vt[i].pg);
                check($sformatf("vec%0d_col", i), cap_col, vt[i].col);
                check($sformatf("vec%0d_fbdata", i), cap_fbd, vt[i].b);
            end
            check($sformatf("vec%0d_disp", i), display_on, vt[i].disp);
            if (i == 0) check("latency", bv_cyc - edge_cyc, 4);
        end

        // Partial byte aborted by chip select, then a full data byte.
        do_reset();
        v0 = vcount;
        spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        send_bits(1, 8'b10111000, 5);
        spi_cs_n = 1'b1;
        repeat (10) @(negedge clk);
        check("abort_no_valid", vcount - v0, 0);
        send_byte(1, 8'hA5);
        $display("abort: valid=%0d byte=%02h p=%0d c=%0d", vcount - v0, cap_data, cap_page, cap_col);
        check("abort_count", vcount - v0, 1);
        check("abort_data", cap_fbd, 8'hA5);
        check("abort_addr", {cap_we, cap_page, cap_col}, {1'b1, 3'd0, 7'd0});

        // Pending column argument abandoned by a data byte.
        send_byte(0, 8'hAF);
        send_byte(0, 8'h21);
        send_byte(1, 8'h3C);
        $display("abandon: we=%0d p=%0d c=%0d data=%02h", cap_we, cap_page, cap_col, cap_fbd);
        check("abandon_write", {cap_we, cap_page, cap_col, cap_fbd}, {1'b1, 3'd0, 7'd1, 8'h3C});
        send_byte(0, 8'hAE);
        check("abandon_idle_disp", display_on, 0);
        send_byte(1, 8'h11);
        $display("abandon next: p=%0d c=%0d", cap_page, cap_col);
        check("abandon_next_addr", {cap_page, cap_col}, {3'd0, 7'd2});

        // Page and split column address commands.
        send_byte(0, 8'hB4);
        send_byte(0, 8'h0A);
        send_byte(0, 8'h12);
        send_byte(1, 8'hFF);
        $display("setaddr: p=%0d c=%02h data=%02h", cap_page, cap_col, cap_fbd);
        check("setaddr", {cap_we, cap_page, cap_col, cap_fbd}, {1'b1, 3'd4, 7'h2A, 8'hFF});

        // Reset in the middle of a byte.
        send_byte(0, 8'hAF);
        spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        send_bits(1, 8'hFF, 3);
        v0 = vcount;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        spi_cs_n = 1'b1;
        repeat (4) @(negedge clk);
        check("midrst_no_valid", vcount - v0, 0);
        check("midrst_disp", display_on, 0);
        send_byte(1, 8'h55);
        $display("midrst: valid=%0d p=%0d c=%0d data=%02h disp=%0d",
                 vcount - v0, cap_page, cap_col, cap_fbd, display_on);
        check("midrst_count", vcount - v0, 1);
        check("midrst_write", {cap_we, cap_page, cap_col, cap_fbd}, {1'b1, 3'd0, 7'd0, 8'h55});
        check("midrst_disp_after", display_on, 0);

        check("no_stray_we", we_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net: a stalled run still ends with a failure report.
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
